// File: rtl/mem_access_unit.sv
// Data-memory access unit: byte/half/word loads and stores
// over a single-ported word memory, with RMW for sub-word stores.
module mem_access_unit #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic        we_q;
  logic        sgn_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] wr_word;

  logic        accept;
  logic        req_bad;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;
  logic [31:0] word_addr;

  assign accept    = (state == IDLE) && req_valid;
  assign word_addr = {addr_q[31:2], 2'b00};

  // Classify the incoming request as illegal before it is accepted
  always_comb begin
    req_bad = 1'b0;
    if (req_size == SZ_X)
      req_bad = 1'b1;
    if (req_size == SZ_H && req_addr[0])
      req_bad = 1'b1;
    if (req_size == SZ_W && req_addr[1:0] != 2'b00)
      req_bad = 1'b1;
    if (req_addr >= LIMIT)
      req_bad = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state and memory/handshake outputs
  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)
            state_nx = RESP;
          else if (req_we && req_size == SZ_W)
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD: begin
        mem_addr = word_addr;
        state_nx = we_q ? WR : RESP;
      end
      WR: begin
        mem_we      = 1'b1;
        mem_addr    = word_addr;
        mem_wr_data = wr_word;
        state_nx    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
    endcase
  end

  // Little-endian lane select and extension of the read word
  always_comb begin
    rd_byte  = mem_rd_data[7:0];
    rd_half  = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    load_val = mem_rd_data;
    unique case (addr_q[1:0])
      2'd0: rd_byte = mem_rd_data[7:0];
      2'd1: rd_byte = mem_rd_data[15:8];
      2'd2: rd_byte = mem_rd_data[23:16];
      2'd3: rd_byte = mem_rd_data[31:24];
    endcase
    unique case (size_q)
      SZ_B: load_val = {{24{sgn_q & rd_byte[7]}}, rd_byte};
      SZ_H: load_val = {{16{sgn_q & rd_half[15]}}, rd_half};
      SZ_W: load_val = mem_rd_data;
      SZ_X: load_val = mem_rd_data;
    endcase
  end

  // Merge sub-word store data into the word just read
  always_comb begin
    merge_val = mem_rd_data;
    if (size_q == SZ_B) begin
      unique case (addr_q[1:0])
        2'd0: merge_val[7:0]   = wdata_q[7:0];
        2'd1: merge_val[15:8]  = wdata_q[7:0];
        2'd2: merge_val[23:16] = wdata_q[7:0];
        2'd3: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (size_q == SZ_H) begin
      if (addr_q[1])
        merge_val[31:16] = wdata_q;
      else
        merge_val[15:0] = wdata_q;
    end
  end

  // Latch request fields at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      sgn_q   <= req_signed;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata[15:0];
    end
  end

  // Write word: full store data, or the merged word leaving RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wr_word <= '0;
    else if (accept)
      wr_word <= req_wdata;
    else if (state == RD)
      wr_word <= merge_val;
  end

  // Response registers update only on entry to RESP, then hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (state != RESP && state_nx == RESP) begin
      resp_err   <= (state == IDLE);
      resp_rdata <= (state == RD && !we_q) ? load_val : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural
// word memory; directed vectors, monitor pops on resp/write.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  mem_access_unit #(.MEM_BYTES(128)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:31];
  assign mem_rd_data = mem[mem_addr[6:2]];
  always @(posedge clk)
    if (mem_we) mem[mem_addr[6:2]] <= mem_wr_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop expected responses and writes as the DUT shows them
  always @(negedge clk) begin
    resp_t e;
    wr_t   w;
    if (resp_valid) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
      end else begin
        e = rq.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got mem_we=1 addr %h expected 0",
                 mem_addr);
      end else begin
        w = wq.pop_front();
        check("mem_addr_wr", mem_addr, w.addr);
        check("mem_wr_data", mem_wr_data, w.data);
      end
    end
    if (req_ready || resp_valid) begin
      check("idle_mem_addr", mem_addr, 32'h0);
      check("idle_mem_wr_data", mem_wr_data, 32'h0);
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wq.push_back('{a, d});
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1");
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat);
    wait_ready();
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    rq.push_back('{exp_rdata, exp_err, cyc + 1, lat});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wr_data", mem_wr_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // word store then word load
    expect_wr(32'h08, 32'hDEADBEEF);
    issue(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0, 2);
    issue(0, 2'b10, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, 2);

    // byte store RMW into 0x11223344
    expect_wr(32'h0C, 32'h11223344);
    issue(1, 2'b10, 0, 32'h0C, 32'h11223344, 32'h0, 0, 2);
    expect_wr(32'h0C, 32'h11AA3344);
    issue(1, 2'b00, 0, 32'h0E, 32'hFFFFFFAA, 32'h0, 0, 3);

    // load extension on 0x11AA3344
    issue(0, 2'b00, 1, 32'h0E, 32'h0, 32'hFFFFFFAA, 0, 2);
    issue(0, 2'b01, 0, 32'h0E, 32'h0, 32'h000011AA, 0, 2);
    issue(0, 2'b01, 1, 32'h0E, 32'h0, 32'h000011AA, 0, 2);
    issue(0, 2'b00, 0, 32'h0F, 32'h0, 32'h00000011, 0, 2);
    issue(0, 2'b00, 1, 32'h0C, 32'h0, 32'h00000044, 0, 2);

    // half store RMW and signed half load
    expect_wr(32'h0C, 32'h11AA8001);
    issue(1, 2'b01, 0, 32'h0C, 32'h12348001, 32'h0, 0, 3);
    issue(0, 2'b01, 1, 32'h0C, 32'h0, 32'hFFFF8001, 0, 2);

    // last word in range
    expect_wr(32'h7C, 32'h12345678);
    issue(1, 2'b10, 0, 32'h7C, 32'h12345678, 32'h0, 0, 2);
    issue(0, 2'b00, 0, 32'h7D, 32'h0, 32'h00000056, 0, 2);
    issue(0, 2'b00, 1, 32'h7F, 32'h0, 32'h00000012, 0, 2);

    // reset during WR of a sub-word store
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_signed = 1'b0;
    req_addr  = 32'h08;
    req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("wr_mem_we", {31'b0, mem_we}, 32'h1);
    check("wr_mem_addr", mem_addr, 32'h08);
    rst_n = 1'b0;
    #1;
    check("rst_wr_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_wr_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_wr_resp_rdata", resp_rdata, 32'h0);
    check("rst_wr_mem_addr", mem_addr, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mem_after_rst", mem[2], 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, 2);

    // errors: misaligned word, misaligned half, size 11, out of range
    issue(0, 2'b10, 0, 32'h06, 32'h0, 32'h0, 1, 1);
    issue(1, 2'b01, 0, 32'h03, 32'hFFFF, 32'h0, 1, 1);
    issue(0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1, 1);
    issue(0, 2'b10, 0, 32'h80, 32'h0, 32'h0, 1, 1);
    issue(1, 2'b00, 0, 32'h80, 32'h77, 32'h0, 1, 1);

    // back-to-back loads with req_valid held high
    wait_ready();
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h08;
    rq.push_back('{32'hDEADBEEF, 1'b0, cyc + 1, 2});
    @(negedge clk);
    check("b2b_ready_rd", {31'b0, req_ready}, 32'h0);
    req_addr = 32'h0C;
    @(negedge clk);
    check("b2b_ready_resp", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    check("b2b_ready_idle", {31'b0, req_ready}, 32'h1);
    rq.push_back('{32'h11AA8001, 1'b0, cyc + 1, 2});
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rdata_hold", resp_rdata, 32'h11AA8001);

    t = 0;
    while ((rq.size() != 0 || wq.size() != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("pending_resp", 32'(rq.size()), 32'h0);
    check("pending_write", 32'(wq.size()), 32'h0);
    check("mem_0c_final", mem[3], 32'h11AA8001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
